// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter - synchronous binary up/down counter with terminal-count flags.
//
// Counts every clock: up when m=1, down when m=0. At the limits the counter
// either wraps modulo 2^WIDTH (WRAP=1) or holds the limit value (WRAP=0).
//
// Parameters
//   WIDTH       counter width in bits (2..32)
//   WRAP        1 = wrap-around, 0 = saturate at 0 / 2^WIDTH-1
//   RESET_VALUE value loaded on reset
//
// Ports
//   clk      rising-edge clock
//   m        direction select, 1 = up, 0 = down
//   rst      synchronous active-high reset, has priority over counting
//   count    registered count value
//   at_max   high while count == 2^WIDTH-1 (decode of the count register)
//   at_zero  high while count == 0 (decode of the count register)
//   wrap     registered pulse, high in the cycle after the count wrapped or
//            was held against a limit
// -----------------------------------------------------------------------------
module counter #(
  parameter int unsigned      WIDTH       = 4,
  parameter bit               WRAP        = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             m,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic             limit_hit;

  // Flags decode the register directly so they only change after clk.
  assign at_max  = (count_reg == MAX_VALUE);
  assign at_zero = (count_reg == '0);

  always_comb begin
    // A step past the limit in the requested direction is the only event
    // that raises wrap, whether the counter then wraps or saturates.
    limit_hit  = m ? at_max : at_zero;
    count_next = m ? (count_reg + ONE) : (count_reg - ONE);
    if (limit_hit && !WRAP) begin
      count_next = count_reg;
    end
    wrap_next = limit_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= RESET_VALUE;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter - self-checking bench for counter.
//
// Two instances share clk/m/rst: one wrapping (WRAP=1) and one saturating
// (WRAP=0), both WIDTH=4. A reference model with plain integer arithmetic
// predicts each count and wrap, and every cycle both instances are compared
// against it. Directed steps follow the test plan, then random m/rst.
// -----------------------------------------------------------------------------
module tb_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         m   = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] count_w, count_s;
  logic         at_max_w, at_zero_w, wrap_w;
  logic         at_max_s, at_zero_s, wrap_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected counts and wrap flags of both instances.
  int exp_w = 0, exp_s = 0;
  int expw_w = 0, expw_s = 0;
  bit model_valid = 1'b0;

  counter #(.WIDTH(W), .WRAP(1'b1), .RESET_VALUE('0)) dut_wrap (
    .clk(clk), .m(m), .rst(rst),
    .count(count_w), .at_max(at_max_w), .at_zero(at_zero_w), .wrap(wrap_w)
  );

  counter #(.WIDTH(W), .WRAP(1'b0), .RESET_VALUE('0)) dut_sat (
    .clk(clk), .m(m), .rst(rst),
    .count(count_s), .at_max(at_max_s), .at_zero(at_zero_s), .wrap(wrap_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One model step from the rules: reset loads 0; otherwise add +/-1 and
  // either reduce modulo 2^W or clamp, flagging any attempt to leave 0..MAXV.
  task automatic model_step(input bit wrap_mode, input int cur, input bit up,
                            input bit r, output int nxt, output int wflag);
    int raw;
    if (r) begin
      nxt   = 0;
      wflag = 0;
    end else begin
      raw   = up ? cur + 1 : cur - 1;
      wflag = (raw < 0 || raw > MAXV) ? 1 : 0;
      if (wrap_mode) nxt = (raw + MAXV + 1) % (MAXV + 1);
      else           nxt = (raw < 0) ? 0 : ((raw > MAXV) ? MAXV : raw);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":wrap.count"},   32'(count_w),   32'(exp_w));
    check({tag, ":wrap.wrap"},    32'(wrap_w),    32'(expw_w));
    check({tag, ":wrap.at_max"},  32'(at_max_w),  32'(exp_w == MAXV));
    check({tag, ":wrap.at_zero"}, 32'(at_zero_w), 32'(exp_w == 0));
    check({tag, ":sat.count"},    32'(count_s),   32'(exp_s));
    check({tag, ":sat.wrap"},     32'(wrap_s),    32'(expw_s));
    check({tag, ":sat.at_max"},   32'(at_max_s),  32'(exp_s == MAXV));
    check({tag, ":sat.at_zero"},  32'(at_zero_s), 32'(exp_s == 0));
  endtask

  // Drive inputs away from the active edge, clock once, then compare.
  task automatic step(input string tag, input bit up, input bit r);
    int nw, ns, fw, fs;
    @(negedge clk);
    m   = up;
    rst = r;
    @(posedge clk);
    if (r) model_valid = 1'b1;
    model_step(1'b1, exp_w, up, r, nw, fw);
    model_step(1'b0, exp_s, up, r, ns, fs);
    exp_w = nw; expw_w = fw;
    exp_s = ns; expw_s = fs;
    #1;
    if (model_valid) compare_all(tag);
    $display("[%0t] %-10s rst=%0b m=%0b | wrap-dut count=%0d wrap=%0b | sat-dut count=%0d wrap=%0b",
             $time, tag, r, up, count_w, wrap_w, count_s, wrap_s);
  endtask

  initial begin
    // Reset for 10 cycles with m toggling.
    for (int i = 0; i < 10; i++) step("reset", bit'(i % 2), 1'b1);

    // Down from reset: 15 with wrap, then 14, 13 (sat instance holds 0).
    step("down", 1'b0, 1'b0);
    check("down_first_15", 32'(count_w), 32'd15);
    check("down_first_wrap", 32'(wrap_w), 32'd1);
    step("down", 1'b0, 1'b0);
    step("down", 1'b0, 1'b0);
    check("down_13", 32'(count_w), 32'd13);

    // Up from 13: 14, 15, 0 (wrap pulse), 1.
    for (int i = 0; i < 4; i++) step("up_wrap", 1'b1, 1'b0);
    check("up_wrap_end", 32'(count_w), 32'd1);
    check("up_wrap_pulse_cleared", 32'(wrap_w), 32'd0);

    // Direction reversal from 5: 6,7,8,7,6,5.
    step("reset", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("to5", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("rev_up", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("rev_dn", 1'b0, 1'b0);
    check("reversal_end", 32'(count_w), 32'd5);

    // Saturation: from 14 go up 3 times, then down once.
    step("reset", 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step("to14", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("sat_up", 1'b1, 1'b0);
    check("sat_held_15", 32'(count_s), 32'd15);
    check("sat_held_wrap", 32'(wrap_s), 32'd1);
    step("sat_dn", 1'b0, 1'b0);
    check("sat_dn_14", 32'(count_s), 32'd14);
    check("sat_dn_wrap0", 32'(wrap_s), 32'd0);

    // Mid-run reset at 9 while counting up.
    step("reset", 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step("to9", 1'b1, 1'b0);
    step("mid_rst", 1'b1, 1'b1);
    check("mid_rst_zero", 32'(count_w), 32'd0);
    step("resume", 1'b1, 1'b0);
    check("resume_one", 32'(count_w), 32'd1);

    // Random direction with occasional reset.
    for (int i = 0; i < 300; i++)
      step("random", bit'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
